dual_port_ram_be: RTL

//  True dual-port RAM successor with per-lane byte write enables and selectable

---
 rtl/dp_ram_pkg.sv | 30 +++
 rtl/dual_port_ram_be_if.sv | 35 +++
 rtl/dp_ram_rd_pipe.sv | 38 +++
 rtl/dual_port_ram_be.sv | 115 +++++++++++
 4 files changed

// File: rtl/dp_ram_pkg.sv
// Shared constants, clear-engine state encoding and the byte-lane merge used by dual_port_ram_be.
package dp_ram_pkg;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;
    localparam int RDW_NO_CHANGE   = 2;

    typedef enum logic [1:0] {
        CLR_IDLE  = 2'd0,
        CLR_CLEAR = 2'd1,
        CLR_DONE  = 2'd2
    } clr_state_e;

    // Widest word the merge supports; callers zero-extend and truncate.
    localparam int MERGE_W = 256;

    function automatic logic [MERGE_W-1:0] lane_merge(
        input logic [MERGE_W-1:0] old_w,
        input logic [MERGE_W-1:0] new_w,
        input logic [MERGE_W-1:0] we,
        input int unsigned        bw
    );
        logic [MERGE_W-1:0] r;
        for (int b = 0; b < MERGE_W; b++) begin
            r[b] = we[8'(b / bw)] ? new_w[b] : old_w[b];
        end
        return r;
    endfunction

endpackage

// File: rtl/dual_port_ram_be_if.sv
// Two-port RAM bus: per-port enable/byte-enable/address/data plus clear and collision status.
interface dual_port_ram_be_if #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    localparam int NB = DATA_WIDTH / BYTE_WIDTH;

    logic                  clr_req;
    logic                  clr_busy;
    logic                  en_a;
    logic                  en_b;
    logic [NB-1:0]         we_a;
    logic [NB-1:0]         we_b;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic [DATA_WIDTH-1:0] din_a;
    logic [DATA_WIDTH-1:0] din_b;
    logic [DATA_WIDTH-1:0] dout_a;
    logic [DATA_WIDTH-1:0] dout_b;
    logic                  rvld_a;
    logic                  rvld_b;
    logic                  coll;

    modport master (
        output clr_req, en_a, en_b, we_a, we_b, addr_a, addr_b, din_a, din_b,
        input  clr_busy, dout_a, dout_b, rvld_a, rvld_b, coll
    );

    modport slave (
        input  clr_req, en_a, en_b, we_a, we_b, addr_a, addr_b, din_a, din_b,
        output clr_busy, dout_a, dout_b, rvld_a, rvld_b, coll
    );

endinterface

// File: rtl/dp_ram_rd_pipe.sv
// Read-data/valid pipeline behind the array: 1 or 2 stages, data held while no valid read.
module dp_ram_rd_pipe #(
    parameter int W       = 32,
    parameter int OUT_REG = 1
) (
    input  logic         clk_i,
    input  logic         rstn,
    input  logic         issue,
    input  logic [W-1:0] rdata,
    output logic [W-1:0] dout,
    output logic         rvld
);
    localparam int STAGES = 1 + OUT_REG;

    logic [STAGES:1]         vld_q;
    logic [STAGES:1][W-1:0]  dat_q;
    logic [STAGES:0]         vld_pipe;
    logic [STAGES:0][W-1:0]  dat_pipe;

    assign vld_pipe = {vld_q, issue};
    assign dat_pipe = {dat_q, rdata};

    always_ff @(posedge clk_i) begin
        if (!rstn) begin
            vld_q <= '0;
            dat_q <= '0;
        end else begin
            for (int s = 1; s <= STAGES; s++) begin
                vld_q[s] <= vld_pipe[s-1];
                if (vld_pipe[s-1]) dat_q[s] <= dat_pipe[s-1];
            end
        end
    end

    assign dout = dat_pipe[STAGES];
    assign rvld = vld_pipe[STAGES];

endmodule

// File: rtl/dual_port_ram_be.sv
// True dual-port byte-enable RAM with selectable read-during-write, collision flag and clear engine.
module dual_port_ram_be
    import dp_ram_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    BYTE_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 4,
    parameter int                    OUT_REG    = 1,
    parameter int                    RDW_MODE   = RDW_READ_FIRST,
    parameter logic [DATA_WIDTH-1:0] CLR_VALUE  = '0
) (
    input  logic               clk_i,
    input  logic               rstn,
    dual_port_ram_be_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    clr_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  busy, clr_wr;
    logic                  ena, enb, wr_a, wr_b, same, coll_q;
    logic [DATA_WIDTH-1:0] old_a, old_b, word_a, word_b, word_a_st;
    logic [1:0]                 iss;
    logic [1:0][DATA_WIDTH-1:0] rdata;
    logic [1:0][DATA_WIDTH-1:0] dout;
    logic [1:0]                 rvld;

    assign busy  = (state_q != CLR_IDLE);
    assign ena   = bus.en_a & ~busy;
    assign enb   = bus.en_b & ~busy;
    assign wr_a  = ena & (|bus.we_a);
    assign wr_b  = enb & (|bus.we_b);
    assign same  = (bus.addr_a == bus.addr_b);

    assign old_a  = mem[bus.addr_a];
    assign old_b  = mem[bus.addr_b];
    assign word_a = DATA_WIDTH'(lane_merge(MERGE_W'(old_a), MERGE_W'(bus.din_a),
                                           MERGE_W'(bus.we_a), BYTE_WIDTH));
    assign word_b = DATA_WIDTH'(lane_merge(MERGE_W'(old_b), MERGE_W'(bus.din_b),
                                           MERGE_W'(bus.we_b), BYTE_WIDTH));
    // Same-address double write: lay A over B's merge so A wins shared lanes only.
    assign word_a_st = (wr_b && same)
                     ? DATA_WIDTH'(lane_merge(MERGE_W'(word_b), MERGE_W'(bus.din_a),
                                              MERGE_W'(bus.we_a), BYTE_WIDTH))
                     : word_a;

    assign rdata[0] = (RDW_MODE == RDW_WRITE_FIRST && wr_a) ? word_a : old_a;
    assign rdata[1] = (RDW_MODE == RDW_WRITE_FIRST && wr_b) ? word_b : old_b;
    assign iss[0]   = ena & (~wr_a | (RDW_MODE != RDW_NO_CHANGE));
    assign iss[1]   = enb & (~wr_b | (RDW_MODE != RDW_NO_CHANGE));

    assign clr_wr = (state_q == CLR_CLEAR) && rstn;

    always_ff @(posedge clk_i) begin
        if (clr_wr) begin
            mem[cnt_q] <= CLR_VALUE;
        end else begin
            if (wr_b && !(wr_a && same)) mem[bus.addr_b] <= word_b;
            if (wr_a)                    mem[bus.addr_a] <= word_a_st;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn) begin
            state_q <= CLR_IDLE;
            cnt_q   <= '0;
            coll_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            coll_q  <= ena & enb & same & (wr_a | wr_b);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLR_IDLE: begin
                cnt_d = '0;
                if (bus.clr_req) state_d = CLR_CLEAR;
            end
            CLR_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) state_d = CLR_DONE;
            end
            CLR_DONE: state_d = CLR_IDLE;
            default:  state_d = CLR_IDLE;
        endcase
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        dp_ram_rd_pipe #(
            .W       (DATA_WIDTH),
            .OUT_REG (OUT_REG)
        ) u_rd_pipe (
            .clk_i (clk_i),
            .rstn  (rstn),
            .issue (iss[p]),
            .rdata (rdata[p]),
            .dout  (dout[p]),
            .rvld  (rvld[p])
        );
    end

    assign bus.dout_a   = dout[0];
    assign bus.dout_b   = dout[1];
    assign bus.rvld_a   = rvld[0];
    assign bus.rvld_b   = rvld[1];
    assign bus.coll     = coll_q;
    assign bus.clr_busy = busy;

endmodule
